// File: rtl/seven_segment_scan_ctrl.sv
// Multiplexed N-digit seven-segment driver with hex or double-dabble decimal
// display, leading-zero blanking and overflow dashes.
module seven_segment_scan_ctrl #(
   parameter int N_DIGITS     = 8,
   parameter int DATA_W       = 32,
   parameter int REFRESH_BITS = 18
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   num_in,
   input  logic                num_valid,
   input  logic                base_sel,
   input  logic                blank_lz,
   output logic                busy,
   output logic                overflow,
   output logic [N_DIGITS-1:0] an_out,
   output logic [7:0]          c_out
);

   localparam int DW = 4 * N_DIGITS;
   localparam int EW = (DATA_W > DW) ? DATA_W : DW;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_COMMIT
   } state_t;

   state_t state_q, state_d;

   logic [DATA_W-1:0]       sh_q, sh_d;
   logic [DW-1:0]           bcd_q, bcd_d;
   logic                    ovs_q, ovs_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [DW-1:0]           disp_q, disp_d;
   logic                    ovf_q, ovf_d;
   logic [REFRESH_BITS-1:0] ref_q, ref_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [N_DIGITS-1:0]     an_q, an_d;
   logic [7:0]              seg_q, seg_d;

   logic [EW-1:0] ext;
   logic [DW-1:0] hex_dig;
   logic          hex_ovf;
   logic [DW-1:0] bcd_adj;
   logic [3:0]    nib;
   logic          nz_hi;
   logic          blank;

   function automatic logic [7:0] seg7(input logic [3:0] v);
      logic [7:0] s;
      unique case (v)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h98;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // Hex path: zero-extend narrow inputs, flag bits that spill past the digits
   assign ext     = EW'(num_in);
   assign hex_dig = ext[DW-1:0];

   generate
      if (EW > DW) begin : g_hex_ovf
         assign hex_ovf = |ext[EW-1:DW];
      end else begin : g_hex_fit
         assign hex_ovf = 1'b0;
      end
   endgenerate

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (num_valid && base_sel) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (cnt_q == CW'(DATA_W - 1)) state_d = S_COMMIT;
         end
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q != S_IDLE);
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      sh_d   = sh_q;
      bcd_d  = bcd_q;
      ovs_d  = ovs_q;
      cnt_d  = cnt_q;
      disp_d = disp_q;
      ovf_d  = ovf_q;
      if (state_q == S_IDLE && num_valid) begin
         if (base_sel) begin
            sh_d  = num_in;
            bcd_d = '0;
            ovs_d = 1'b0;
            cnt_d = '0;
         end else begin
            disp_d = hex_dig;
            ovf_d  = hex_ovf;
         end
      end
      if (state_q == S_SHIFT) begin
         sh_d  = sh_q << 1;
         bcd_d = {bcd_adj[DW-2:0], sh_q[DATA_W-1]};
         ovs_d = ovs_q | bcd_adj[DW-1];
         cnt_d = cnt_q + 1'b1;
      end
      if (state_q == S_COMMIT) begin
         disp_d = bcd_q;
         ovf_d  = ovs_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_q   <= '0;
         bcd_q  <= '0;
         ovs_q  <= 1'b0;
         cnt_q  <= '0;
         disp_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         bcd_q  <= bcd_d;
         ovs_q  <= ovs_d;
         cnt_q  <= cnt_d;
         disp_q <= disp_d;
         ovf_q  <= ovf_d;
      end
   end

   // Scan: select current nibble and decide whether it sits in the zero prefix
   always_comb begin
      nib   = '0;
      nz_hi = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_q == IW'(i)) nib = disp_q[4*i +: 4];
         if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'd0) nz_hi = 1'b1;
      end
      blank = blank_lz && (idx_q != '0) && !nz_hi;
   end

   always_comb begin
      ref_d = ref_q + 1'b1;
      idx_d = idx_q;
      if (&ref_q) begin
         idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      an_d = ~(N_DIGITS'(1) << idx_q);
      if (ovf_q) begin
         seg_d = 8'hBF;
      end else if (blank) begin
         seg_d = 8'hFF;
      end else begin
         seg_d = seg7(nib);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_q <= '0;
         idx_q <= '0;
         an_q  <= '1;
         seg_q <= 8'hFF;
      end else begin
         ref_q <= ref_d;
         idx_q <= idx_d;
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign overflow = ovf_q;
   assign an_out   = an_q;
   assign c_out    = seg_q;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed scoreboard bench for seven_segment_scan_ctrl: expected digit
// patterns come from a division-based display model.
module tb_seven_segment_scan_ctrl;

   localparam int N  = 8;
   localparam int W  = 32;
   localparam int RB = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] num_in;
   logic         num_valid;
   logic         base_sel;
   logic         blank_lz;
   logic         busy;
   logic         overflow;
   logic [N-1:0] an_out;
   logic [7:0]   c_out;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      int         idx;
      logic [7:0] seg;
   } exp_t;

   exp_t sb[$];

   seven_segment_scan_ctrl #(
      .N_DIGITS    (N),
      .DATA_W      (W),
      .REFRESH_BITS(RB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .num_in   (num_in),
      .num_valid(num_valid),
      .base_sel (base_sel),
      .blank_lz (blank_lz),
      .busy     (busy),
      .overflow (overflow),
      .an_out   (an_out),
      .c_out    (c_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] seg7(input logic [3:0] v);
      logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                             8'h82, 8'hF8, 8'h80, 8'h98, 8'h88, 8'h83,
                             8'hC6, 8'hA1, 8'h86, 8'h8E};
      return t[v];
   endfunction

   function automatic logic [7:0] model_seg(input longint unsigned v,
                                            input bit dec, input bit blk,
                                            input int idx);
      logic [3:0]       dg [N];
      longint unsigned  tmp;
      bit               zero_hi;
      tmp = v;
      for (int i = 0; i < N; i++) begin
         if (dec) begin
            dg[i] = 4'(tmp % 10);
            tmp   = tmp / 10;
         end else begin
            dg[i] = 4'(tmp & 15);
            tmp   = tmp >> 4;
         end
      end
      if (tmp != 0) return 8'hBF;
      zero_hi = 1'b1;
      for (int i = idx; i < N; i++) if (dg[i] != 0) zero_hi = 1'b0;
      if (blk && idx > 0 && zero_hi) return 8'hFF;
      return seg7(dg[idx]);
   endfunction

   task automatic push_display(input longint unsigned v, input bit dec,
                               input bit blk);
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.idx = i;
         e.seg = model_seg(v, dec, blk, i);
         sb.push_back(e);
      end
   endtask

   task automatic drain(input string tag);
      exp_t         e;
      logic [N-1:0] want;
      int           t;
      while (sb.size() > 0) begin
         e    = sb.pop_front();
         want = ~(N'(1) << e.idx);
         t    = 0;
         while (an_out !== want && t < 64) begin
            @(negedge clk);
            t++;
         end
         if (an_out !== want) begin
            chk($sformatf("%s_an_timeout_d%0d", tag, e.idx), an_out, want);
         end else begin
            chk($sformatf("%s_d%0d", tag, e.idx), c_out, e.seg);
         end
      end
   endtask

   task automatic load(input logic [W-1:0] v, input bit dec);
      @(negedge clk);
      num_in    = v;
      base_sel  = dec;
      num_valid = 1'b1;
      @(negedge clk);
      num_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk(tag, busy, 1'b0);
   endtask

   initial begin
      int c;
      reset     = 1'b1;
      num_in    = '0;
      num_valid = 1'b0;
      base_sel  = 1'b0;
      blank_lz  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an", an_out, 8'hFF);
      chk("rst_c", c_out, 8'hFF);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      reset = 1'b0;

      // Hex load
      load(32'h1234ABCD, 1'b0);
      chk("hex_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      chk("hex_ovf", overflow, 1'b0);
      push_display(64'h1234ABCD, 1'b0, 1'b0);
      drain("hex");

      // Decimal load and busy length
      load(32'd98765432, 1'b1);
      c = 0;
      while (busy && c < 100) begin
         c++;
         @(negedge clk);
      end
      chk("dec_busy_len", c, 33);
      repeat (2) @(negedge clk);
      chk("dec_ovf", overflow, 1'b0);
      push_display(64'd98765432, 1'b1, 1'b0);
      drain("dec");

      // Decimal overflow
      load(32'd100000000, 1'b1);
      wait_idle("ovf_idle");
      repeat (2) @(negedge clk);
      chk("ovf_flag", overflow, 1'b1);
      push_display(64'd100000000, 1'b1, 1'b0);
      drain("ovf");

      // Leading-zero blanking, then live disable
      blank_lz = 1'b1;
      load(32'd42, 1'b1);
      wait_idle("lz_idle");
      repeat (2) @(negedge clk);
      chk("lz_ovf", overflow, 1'b0);
      push_display(64'd42, 1'b1, 1'b1);
      drain("lz_on");
      blank_lz = 1'b0;
      repeat (2) @(negedge clk);
      push_display(64'd42, 1'b1, 1'b0);
      drain("lz_off");

      // Strobe while busy is dropped
      load(32'd12345, 1'b1);
      repeat (2) @(negedge clk);
      num_in    = 32'd7;
      base_sel  = 1'b1;
      num_valid = 1'b1;
      @(negedge clk);
      num_valid = 1'b0;
      wait_idle("drop_idle");
      repeat (2) @(negedge clk);
      chk("drop_busy_after", busy, 1'b0);
      push_display(64'd12345, 1'b1, 1'b0);
      drain("drop");

      // Reset in the middle of a conversion
      load(32'd12345, 1'b1);
      repeat (9) @(negedge clk);
      chk("mid_busy", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_an", an_out, 8'hFF);
      chk("mid_rst_c", c_out, 8'hFF);
      chk("mid_rst_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_ovf", overflow, 1'b0);
      push_display(64'd0, 1'b0, 1'b0);
      drain("post_rst");
      load(32'd5, 1'b0);
      repeat (2) @(negedge clk);
      push_display(64'd5, 1'b0, 1'b0);
      drain("post_hex");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
